sipo_deserializer: RTL and testbench

//   Serial-in / parallel-out capture stage; sits directly downstream of the dff

---
 rtl/sipo_deserializer_if.sv | 34 +++
 rtl/sipo_deserializer.sv | 114 +++++++++++
 tb/tb_sipo_deserializer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/sipo_deserializer_if.sv
// ============================================================================
// Module      : sipo_deserializer_if
// Description : Serial input, control and valid/ready word output bundle of
//               the SIPO deserializer.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sipo_deserializer_if #(
  parameter int WIDTH = 8
);
  logic             sin;
  logic             sin_en;
  logic             clr;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;

  // Producer/consumer side: drives serial bits, control and ready.
  modport master (
    output sin, sin_en, clr, out_ready,
    input  pout, pout_valid, busy, overrun
  );

  // Deserializer side.
  modport slave (
    input  sin, sin_en, clr, out_ready,
    output pout, pout_valid, busy, overrun
  );
endinterface

`default_nettype wire

// File: rtl/sipo_deserializer.sv
// ============================================================================
// Module      : sipo_deserializer
// Description : Serial-in / parallel-out capture stage. Assembles WIDTH bits
//               MSB-first and presents them on a double-buffered valid/ready
//               port, flagging words lost to a stalled consumer (overrun).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sipo_deserializer #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  sipo_deserializer_if.slave    bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_word;
  logic             w_complete;
  logic [WIDTH-1:0] r_pout;
  logic             r_pout_valid;
  logic             r_overrun;

  // Word as it stands once the bit sampled on this edge is shifted in.
  assign w_word = {r_sr[WIDTH-2:0], bus.sin};

  // Next-state, shift and bit-count decode; completion fires on the last bit.
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    w_complete  = 1'b0;
    if (bus.sin_en) begin
      w_sr_nxt = w_word;
      case (r_state)
        IDLE: begin
          w_state_nxt = SHIFT;
          w_cnt_nxt   = CW'(1);
        end
        SHIFT: begin
          if (r_cnt == CW'(WIDTH - 1)) begin
            w_complete  = 1'b1;
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, shift register and bit counter; clr aborts any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
    end else if (bus.clr) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Output holding buffer: load, drop-with-overrun, or consume, in that order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pout       <= '0;
      r_pout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (bus.clr) begin
      // pout deliberately keeps its last value; only the valid flag drops.
      r_pout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_complete && (!r_pout_valid || bus.out_ready)) begin
      r_pout       <= w_word;
      r_pout_valid <= 1'b1;
    end else if (w_complete) begin
      r_overrun <= 1'b1;
    end else if (r_pout_valid && bus.out_ready) begin
      r_pout_valid <= 1'b0;
    end
  end

  assign bus.pout       = r_pout;
  assign bus.pout_valid = r_pout_valid;
  assign bus.overrun    = r_overrun;
  assign bus.busy       = (r_state == SHIFT);

endmodule

`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
// ============================================================================
// Module      : tb_sipo_deserializer
// Description : Directed self-checking bench for sipo_deserializer (WIDTH=8).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sipo_deserializer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  sipo_deserializer_if #(.WIDTH(8)) bus ();

  sipo_deserializer #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one bit on sin_en for a single edge, then idle for gap edges.
  task automatic send_bit(input logic b, input int gap);
    bus.sin    = b;
    bus.sin_en = 1'b1;
    tick();
    bus.sin_en = 1'b0;
    repeat (gap) tick();
  endtask

  // Shift the first n bits of w (MSB first) back to back.
  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[7-i], 0);
  endtask

  initial begin
    n_checks      = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.sin       = 1'b0;
    bus.sin_en    = 1'b0;
    bus.clr       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    chk("rst_pout", 32'(bus.pout), 32'h00);
    chk("rst_valid", 32'(bus.pout_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_overrun", 32'(bus.overrun), 0);
    #2 rst = 1'b0;

    // 1: back-to-back 8'hB2 with consumer ready
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send_bit(((8'hB2 >> (7 - i)) & 8'h1) != 0, 0);
      chk("t1_busy", 32'(bus.busy), 1);
      chk("t1_novalid", 32'(bus.pout_valid), 0);
    end
    send_bit(1'b0, 0);
    chk("t1_valid", 32'(bus.pout_valid), 1);
    chk("t1_pout", 32'(bus.pout), 32'hB2);
    chk("t1_busy_end", 32'(bus.busy), 0);
    tick();
    chk("t1_valid_1cyc", 32'(bus.pout_valid), 0);

    // 2: same word with sin_en asserted one edge in three
    for (int i = 0; i < 7; i++) begin
      send_bit(((8'hB2 >> (7 - i)) & 8'h1) != 0, 2);
      chk("t2_novalid", 32'(bus.pout_valid), 0);
    end
    send_bit(1'b0, 0);
    chk("t2_valid", 32'(bus.pout_valid), 1);
    chk("t2_pout", 32'(bus.pout), 32'hB2);
    tick();
    chk("t2_consumed", 32'(bus.pout_valid), 0);

    // 3: stalled consumer, second word is dropped
    bus.out_ready = 1'b0;
    send_bits(8'hA5, 8);
    chk("t3_valid_a5", 32'(bus.pout_valid), 1);
    chk("t3_pout_a5", 32'(bus.pout), 32'hA5);
    chk("t3_no_ovr", 32'(bus.overrun), 0);
    send_bits(8'h3C, 8);
    chk("t3_pout_held", 32'(bus.pout), 32'hA5);
    chk("t3_ovr", 32'(bus.overrun), 1);
    bus.out_ready = 1'b1;
    tick();
    chk("t3_valid_fall", 32'(bus.pout_valid), 0);
    chk("t3_ovr_sticky", 32'(bus.overrun), 1);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("t3_ovr_clr", 32'(bus.overrun), 0);

    // 4: consume coincides with the next completion
    send_bits(8'h01, 8);
    chk("t4_valid_01", 32'(bus.pout_valid), 1);
    chk("t4_pout_01", 32'(bus.pout), 32'h01);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      send_bit(1'b1, 0);
      chk("t4_hold_valid", 32'(bus.pout_valid), 1);
      chk("t4_hold_pout", 32'(bus.pout), 32'h01);
    end
    bus.out_ready = 1'b1;
    send_bit(1'b1, 0);
    chk("t4_valid_ff", 32'(bus.pout_valid), 1);
    chk("t4_pout_ff", 32'(bus.pout), 32'hFF);
    chk("t4_no_ovr", 32'(bus.overrun), 0);
    tick();
    chk("t4_consumed", 32'(bus.pout_valid), 0);

    // 5: partial word aborted by clr
    send_bits(8'hFF, 5);
    chk("t5_busy", 32'(bus.busy), 1);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("t5_busy_clr", 32'(bus.busy), 0);
    chk("t5_valid_clr", 32'(bus.pout_valid), 0);
    chk("t5_pout_kept", 32'(bus.pout), 32'hFF);
    send_bits(8'h5A, 8);
    chk("t5_valid", 32'(bus.pout_valid), 1);
    chk("t5_pout", 32'(bus.pout), 32'h5A);
    tick();

    // 6: asynchronous reset mid-word
    send_bits(8'hF0, 4);
    chk("t6_busy", 32'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_pout", 32'(bus.pout), 32'h00);
    chk("t6_valid", 32'(bus.pout_valid), 0);
    chk("t6_busy_rst", 32'(bus.busy), 0);
    chk("t6_ovr", 32'(bus.overrun), 0);
    #3 rst = 1'b0;
    tick();
    chk("t6_no_pulse", 32'(bus.pout_valid), 0);
    send_bits(8'hC3, 8);
    chk("t6_valid_c3", 32'(bus.pout_valid), 1);
    chk("t6_pout_c3", 32'(bus.pout), 32'hC3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
